// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the countdown timer bank.
// Channel states, MM:SS BCD layout and digit limits.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SEC_MAX_TENS  = 4'h5;
  localparam logic [3:0] SEC_MAX_ONES  = 4'h9;
  localparam logic [7:0] SEC_MAX       = {SEC_MAX_TENS, SEC_MAX_ONES};
  localparam logic [3:0] MAX_BCD_DIGIT = 4'h9;

  typedef struct packed {
    logic [3:0] min10;
    logic [3:0] min1;
    logic [3:0] sec10;
    logic [3:0] sec1;
  } mmss_t;

  // One-second BCD decrement with borrow through seconds into minutes.
  function automatic mmss_t bcd_dec(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.sec1 != 4'd0) begin
      r.sec1 = t.sec1 - 4'd1;
    end else begin
      r.sec1 = MAX_BCD_DIGIT;
      if (t.sec10 != 4'd0) begin
        r.sec10 = t.sec10 - 4'd1;
      end else begin
        r.sec10 = SEC_MAX_TENS;
        if (t.min1 != 4'd0) begin
          r.min1 = t.min1 - 4'd1;
        end else begin
          r.min1  = MAX_BCD_DIGIT;
          r.min10 = t.min10 - 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] sec_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s == SEC_MAX)
      r = 8'h00;
    else if (s[3:0] == MAX_BCD_DIGIT)
      r = {s[7:4] + 4'd1, 4'd0};
    else
      r = {s[7:4], s[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One MM:SS countdown channel: setpoint, BCD count and state.
// COUNTDOWN_AUTO_RELOAD_EN: reload setpoint on expiry and keep running.
module timer_channel
  import timer_pkg::*;
#(
  parameter int MIN_MAX = 99
) (
  input  logic   clk,
  input  logic   reset_p,
  input  logic   tick,
  input  logic   inc_min,
  input  logic   inc_sec,
  input  logic   start,
  input  logic   clear,
  input  logic   load,
  output mmss_t  setpoint,
  output mmss_t  count,
  output state_t state,
  output logic   alarm
);

  localparam logic [3:0] MM10 = 4'(MIN_MAX / 10);
  localparam logic [3:0] MM1  = 4'(MIN_MAX % 10);

  function automatic logic [7:0] min_inc(input logic [7:0] m);
    logic [7:0] r;
    if (m == {MM10, MM1})
      r = 8'h00;
    else if (m[3:0] == MAX_BCD_DIGIT)
      r = {m[7:4] + 4'd1, 4'd0};
    else
      r = {m[7:4], m[3:0] + 4'd1};
    return r;
  endfunction

  mmss_t dec;
  logic  tick_run;
  logic  do_load;
  logic  do_zero;
  logic  do_rest;

  always_comb begin
    dec      = bcd_dec(count);
    tick_run = tick && (state == RUN);
    do_load  = load | clear;
    do_zero  = !do_load && tick_run && (dec == '0);
    do_rest  = !do_load && !do_zero;
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      setpoint <= '0;
      count    <= '0;
      state    <= IDLE;
      alarm    <= 1'b0;
    end else begin
      if (inc_sec)
        {setpoint.sec10, setpoint.sec1} <=
          sec_inc({setpoint.sec10, setpoint.sec1});
      if (inc_min)
        {setpoint.min10, setpoint.min1} <=
          min_inc({setpoint.min10, setpoint.min1});

      unique case (1'b1)
        do_load: begin
          count <= setpoint;
          state <= IDLE;
          alarm <= 1'b0;
        end
        do_zero: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (setpoint != '0) begin
            count <= setpoint;
            state <= RUN;
          end else begin
            count <= '0;
            state <= DONE;
          end
`else
          count <= '0;
          state <= DONE;
`endif
          alarm <= 1'b1;
        end
        do_rest: begin
          if (tick_run)
            count <= dec;
          if (start) begin
            unique case (state)
              IDLE:  if (count != '0) state <= RUN;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              // A pending alarm is acknowledged instead of pausing.
              RUN: begin
                if (alarm) alarm <= 1'b0;
                else       state <= PAUSE;
              end
`else
              RUN:   state <= PAUSE;
`endif
              PAUSE: state <= RUN;
              DONE: begin
                state <= IDLE;
                count <= setpoint;
                alarm <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/countdown_timer_bank.sv
// Bank of MM:SS countdown timers behind one button/set-mode front end.
// COUNTDOWN_AUTO_RELOAD_EN selects auto-reload in every channel.
module countdown_timer_bank
  import timer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int MIN_MAX = 99,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              tick_sec,
  input  logic [CH_W-1:0]   sel_ch,
  input  logic              btn_set,
  input  logic              btn_inc_min,
  input  logic              btn_inc_sec,
  input  logic              btn_start,
  input  logic              btn_clear,
  output logic [15:0]       value,
  output logic              set_mode,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] alarm,
  output logic              alarm_any
);

  mmss_t  sp_a  [NUM_CH];
  mmss_t  cnt_a [NUM_CH];
  state_t st_a  [NUM_CH];

  logic [NUM_CH-1:0] run_w;
  logic [NUM_CH-1:0] al_w;
  logic              sel_ok;
  mmss_t             value_nxt;

  assign sel_ok = {1'b0, sel_ch} < (CH_W+1)'(NUM_CH);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic hit;
    assign hit = sel_ok && (sel_ch == CH_W'(g));

    timer_channel #(
      .MIN_MAX (MIN_MAX)
    ) u_ch (
      .clk      (clk),
      .reset_p  (reset_p),
      .tick     (tick_sec),
      .inc_min  (hit && set_mode && btn_inc_min),
      .inc_sec  (hit && set_mode && btn_inc_sec),
      .start    (hit && !set_mode && btn_start),
      .clear    (hit && !set_mode && btn_clear),
      .load     (hit && set_mode && btn_set),
      .setpoint (sp_a[g]),
      .count    (cnt_a[g]),
      .state    (st_a[g]),
      .alarm    (al_w[g])
    );

    assign run_w[g] = (st_a[g] == RUN);
  end

  always_comb begin
    value_nxt = '0;
    if (sel_ok)
      value_nxt = set_mode ? sp_a[sel_ch] : cnt_a[sel_ch];
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      set_mode  <= 1'b0;
      value     <= '0;
      running   <= '0;
      alarm     <= '0;
      alarm_any <= 1'b0;
    end else begin
      if (sel_ok && btn_set)
        set_mode <= !set_mode;
      value     <= value_nxt;
      running   <= run_w;
      alarm     <= al_w;
      alarm_any <= |al_w;
    end
  end

endmodule

// File: tb/tb_countdown_timer_bank.sv
// Scoreboard bench for countdown_timer_bank against a seconds-based model.
// Directed scenarios followed by randomized single-button traffic.
module tb_countdown_timer_bank;

  localparam int NUM_CH  = 4;
  localparam int MIN_MAX = 99;
  localparam int CH_W    = 2;

  logic              clk = 1'b0;
  logic              reset_p = 1'b1;
  logic              tick_sec = 1'b0;
  logic [CH_W-1:0]   sel_ch = '0;
  logic              btn_set = 1'b0;
  logic              btn_inc_min = 1'b0;
  logic              btn_inc_sec = 1'b0;
  logic              btn_start = 1'b0;
  logic              btn_clear = 1'b0;
  logic [15:0]       value;
  logic              set_mode;
  logic [NUM_CH-1:0] running;
  logic [NUM_CH-1:0] alarm;
  logic              alarm_any;

  always #5 clk = ~clk;

  countdown_timer_bank #(
    .NUM_CH  (NUM_CH),
    .MIN_MAX (MIN_MAX)
  ) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .tick_sec    (tick_sec),
    .sel_ch      (sel_ch),
    .btn_set     (btn_set),
    .btn_inc_min (btn_inc_min),
    .btn_inc_sec (btn_inc_sec),
    .btn_start   (btn_start),
    .btn_clear   (btn_clear),
    .value       (value),
    .set_mode    (set_mode),
    .running     (running),
    .alarm       (alarm),
    .alarm_any   (alarm_any)
  );

  typedef struct packed {
    logic [15:0]       v;
    logic              sm;
    logic [NUM_CH-1:0] run;
    logic [NUM_CH-1:0] al;
    logic              any;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model: counts kept as plain seconds; state 0 idle 1 run 2 pause 3 done.
  int m_spm [NUM_CH];
  int m_sps [NUM_CH];
  int m_cnt [NUM_CH];
  int m_st  [NUM_CH];
  bit m_al  [NUM_CH];
  bit m_set;
  int cur_sel;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  function automatic logic [15:0] to_bcd(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_spm[c] = 0; m_sps[c] = 0; m_cnt[c] = 0;
      m_st[c] = 0;  m_al[c] = 1'b0;
    end
    m_set = 1'b0;
  endtask

  task automatic step(input bit r, t, s, mi, se, st, cl);
    exp_t e;
    bit   ok;
    int   sp;
    @(negedge clk);
    reset_p     = r;
    tick_sec    = t;
    sel_ch      = CH_W'(cur_sel);
    btn_set     = s;
    btn_inc_min = mi;
    btn_inc_sec = se;
    btn_start   = st;
    btn_clear   = cl;
    ok = (cur_sel < NUM_CH);
    e  = '0;
    if (r) begin
      model_reset();
    end else begin
      if (ok)
        e.v = to_bcd(m_set ? m_spm[cur_sel] * 60 + m_sps[cur_sel]
                           : m_cnt[cur_sel]);
      for (int c = 0; c < NUM_CH; c++) begin
        e.run[c] = (m_st[c] == 1);
        e.al[c]  = m_al[c];
      end
      e.any = |e.al;
      for (int c = 0; c < NUM_CH; c++) begin
        bit hit;
        hit = ok && (cur_sel == c);
        sp  = m_spm[c] * 60 + m_sps[c];
        if (hit && ((m_set && s) || (!m_set && cl))) begin
          m_cnt[c] = sp; m_st[c] = 0; m_al[c] = 1'b0;
        end else if (t && m_st[c] == 1 && m_cnt[c] == 1) begin
          m_al[c] = 1'b1;
          if (AUTO && sp > 0) m_cnt[c] = sp;
          else begin m_cnt[c] = 0; m_st[c] = 3; end
        end else begin
          int st0;
          st0 = m_st[c];
          if (t && st0 == 1) m_cnt[c]--;
          if (hit && !m_set && st) begin
            if (st0 == 0 && m_cnt[c] != 0) m_st[c] = 1;
            else if (st0 == 1) begin
              if (AUTO && m_al[c]) m_al[c] = 1'b0;
              else m_st[c] = 2;
            end
            else if (st0 == 2) m_st[c] = 1;
            else if (st0 == 3) begin
              m_st[c] = 0; m_cnt[c] = sp; m_al[c] = 1'b0;
            end
          end
        end
      end
      if (ok && m_set) begin
        if (se) m_sps[cur_sel] = (m_sps[cur_sel] + 1) % 60;
        if (mi) m_spm[cur_sel] = (m_spm[cur_sel] + 1) % (MIN_MAX + 1);
      end
      if (ok && s) m_set = !m_set;
    end
    e.sm = m_set;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic ticks(input int n);
    repeat (n) step(0, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic press_set();   step(0, 0, 1, 0, 0, 0, 0); endtask
  task automatic press_start(); step(0, 0, 0, 0, 0, 1, 0); endtask
  task automatic inc_sec(input int n);
    repeat (n) step(0, 0, 0, 0, 1, 0, 0);
  endtask
  task automatic inc_min(input int n);
    repeat (n) step(0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("value",     value,                e.v);
        chk("set_mode",  16'(set_mode),        16'(e.sm));
        chk("running",   16'(running),         16'(e.run));
        chk("alarm",     16'(alarm),           16'(e.al));
        chk("alarm_any", 16'(alarm_any),       16'(e.any));
      end
    end
  end

  initial begin
    model_reset();
    cur_sel = 0;
    repeat (2) step(1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Setpoint 03:01 on ch1 with one seconds wrap.
    cur_sel = 1;
    press_set();
    inc_sec(61);
    inc_min(3);
    press_set();
    idle(2);

    // Full countdown of ch1 including minute borrows.
    press_start();
    ticks(181);
    idle(3);

    // Ch0 from 00:10 with pause and resume, then acknowledge.
    cur_sel = 0;
    press_set();
    inc_sec(10);
    press_set();
    press_start();
    ticks(3);
    press_start();
    ticks(5);
    press_start();
    ticks(7);
    idle(2);
    press_start();
    idle(2);

    // Ch2 at 00:01: expiry beats a same-cycle pause.
    cur_sel = 2;
    press_set();
    inc_sec(1);
    press_set();
    press_start();
    step(0, 1, 0, 0, 0, 1, 0);
    idle(2);

    // Ch0/ch3 keep counting while ch1 is edited; then reset mid-run.
    cur_sel = 3;
    press_set();
    inc_min(1);
    press_set();
    press_start();
    cur_sel = 0;
    press_start();
    cur_sel = 1;
    press_set();
    inc_sec(2);
    ticks(4);
    press_set();
    ticks(3);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Setpoint 00:02 run for six ticks (auto-reload build reloads).
    cur_sel = 0;
    press_set();
    inc_sec(2);
    press_set();
    press_start();
    ticks(6);
    press_start();
    idle(2);

    // Wrap of minutes at MIN_MAX on ch3.
    cur_sel = 3;
    press_set();
    inc_min(MIN_MAX + 2);
    press_set();
    idle(2);

    // Randomized single-button traffic.
    for (int i = 0; i < 4000; i++) begin
      int k;
      bit r, t;
      r = ($urandom_range(0, 799) == 0);
      t = ($urandom_range(0, 2) == 0);
      k = $urandom_range(0, 19);
      if ($urandom_range(0, 3) == 0)
        cur_sel = $urandom_range(0, NUM_CH - 1);
      step(r, t, k == 0, k == 1, k == 2 || k == 3,
           k == 4 || k == 5, k == 6);
    end
    idle(2);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
